// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver.
// UART_TX_PARITY_EN adds the PARITY state used for even parity.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  // Cycles per bit, rounded to nearest
  function automatic int unsigned bit_clk(input int unsigned clk_hz,
                                          input int unsigned bitrate_bps);
    return (clk_hz + bitrate_bps / 2) / bitrate_bps;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with registered occupancy count and full/empty flags.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent as 8N1/8N2 frames, LSB first.
// Define UART_TX_PARITY_EN for an even-parity bit (8E1/8E2).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_Hz      = 66_000_000,
  parameter int unsigned BITRATE_bps = 9_600,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] data,
  input  logic                   data_valid,
  output logic                   ready,
  output logic                   tx,
  output logic                   busy
);

  localparam int unsigned      BIT_CLK   = bit_clk(CLK_Hz, BITRATE_bps);
  localparam int unsigned      CNT_W     = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CLK - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   bit_end;
  logic                   load;
  logic                   pop;
  logic [UART_DATA_W-1:0] head;
  logic                   full;
  logic                   empty;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(UART_DATA_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (data_valid),
    .din  (data),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  assign ready = !full;
  assign tx    = tx_q;
  assign busy  = (state_q != TX_IDLE) || !empty;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        load  = !empty;
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
            tx_d    = par_q;
`else
            state_d = TX_STOP;
            idx_d   = '0;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          state_d = TX_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
            load    = !empty;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // Shared frame start: from IDLE or straight out of the last stop bit
    if (load) begin
      pop     = 1'b1;
      state_d = TX_START;
      cnt_d   = '0;
      shift_d = head;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with a short bit period (16 cycles).
module tb_uart_tx;

  localparam int unsigned BC = 16;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned STOPS = 1;
  localparam int unsigned NB    = 10 + STOPS - 1 + PAR;
  localparam int unsigned FRAME = NB * BC;
  localparam int unsigned LIMIT = 4 * FRAME;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       data_valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [31:0] cyc = '0;

  int checks   = 0;
  int failures = 0;

  uart_tx #(
    .CLK_Hz     (1_000_000),
    .BITRATE_bps(62_500),
    .STOP_BITS  (STOPS),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .data_valid(data_valid),
    .ready     (ready),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic p);
    logic [15:0] fb;
    fb      = '1;
    fb[0]   = 1'b0;
    fb[8:1] = d;
    if (PAR == 1) fb[9] = p;
    return fb;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data       = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Mid-bit sampling receiver; returns the cycle of the first low sample
  task automatic rx_byte(output logic [7:0] b, output logic [31:0] start_cyc);
    int unsigned n;
    n = 0;
    b = '0;
    start_cyc = '0;
    @(negedge clk);
    while (tx !== 1'b0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) begin
      check("rx_start_timeout", 32'(n), 32'(LIMIT - 1));
      return;
    end
    start_cyc = cyc;
    repeat (BC / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BC) @(negedge clk);
      b[i] = tx;
    end
    if (PAR == 1) begin
      repeat (BC) @(negedge clk);
      check("rx_parity", 32'(tx), 32'(^b));
    end
    for (int s = 0; s < STOPS; s++) begin
      repeat (BC) @(negedge clk);
      check("rx_stop", 32'(tx), 32'd1);
    end
  endtask

  logic [7:0] fv_d [2] = '{8'h05, 8'hA1};
  logic       fv_p [2] = '{1'b0, 1'b1};
  logic [7:0] burst [3] = '{8'h05, 8'h08, 8'h11};
  logic [7:0] fill  [6] = '{8'h3C, 8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h96};

  initial begin
    int unsigned bad;
    logic [15:0] fb;

    rst_n      = 1'b0;
    data       = '0;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Idle line stays quiet
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Exact per-cycle frame shape, including start latency
    for (int v = 0; v < 2; v++) begin
      fb = frame_bits(fv_d[v], fv_p[v]);
      @(negedge clk);
      check($sformatf("f%0h_ready", fv_d[v]), 32'(ready), 32'd1);
      data       = fv_d[v];
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      check($sformatf("f%0h_latency_tx", fv_d[v]), 32'(tx), 32'd1);
      check($sformatf("f%0h_busy", fv_d[v]), 32'(busy), 32'd1);
      for (int k = 0; k < NB; k++) begin
        bad = 0;
        for (int c = 0; c < BC; c++) begin
          @(negedge clk);
          if (tx !== fb[k]) bad++;
        end
        check($sformatf("f%0h_bit%0d", fv_d[v], k), 32'(bad), 32'd0);
      end
      @(negedge clk);
      check($sformatf("f%0h_end_busy", fv_d[v]), 32'(busy), 32'd0);
      check($sformatf("f%0h_end_tx", fv_d[v]), 32'(tx), 32'd1);
    end

    // Burst on consecutive cycles: back-to-back frames in order
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check($sformatf("burst_ready%0d", i), 32'(ready), 32'd1);
          data       = burst[i];
          data_valid = 1'b1;
        end
        @(negedge clk);
        data_valid = 1'b0;
      end
      begin
        logic [7:0]  b;
        logic [31:0] s [3];
        for (int i = 0; i < 3; i++) begin
          rx_byte(b, s[i]);
          check($sformatf("burst_byte%0d", i), 32'(b), 32'(burst[i]));
        end
        check("burst_gap1", s[1] - s[0], 32'(FRAME));
        check("burst_gap2", s[2] - s[1], 32'(FRAME));
      end
    join
    repeat (BC) @(negedge clk);
    check("burst_idle_busy", 32'(busy), 32'd0);

    // Overfill with data_valid held: back-pressure, no loss or duplication
    fork
      begin
        int unsigned i, n;
        logic saw_full;
        i = 0;
        n = 0;
        saw_full = 1'b0;
        while (i < 6 && n < LIMIT * 6) begin
          @(negedge clk);
          n++;
          data       = fill[i];
          data_valid = 1'b1;
          if (ready) i++;
          else saw_full = 1'b1;
        end
        @(negedge clk);
        data_valid = 1'b0;
        check("fill_accepted", 32'(i), 32'd6);
        check("fill_ready_dropped", 32'(saw_full), 32'd1);
      end
      begin
        logic [7:0]  b;
        logic [31:0] s;
        for (int i = 0; i < 6; i++) begin
          rx_byte(b, s);
          check($sformatf("fill_byte%0d", i), 32'(b), 32'(fill[i]));
        end
      end
    join
    repeat (BC) @(negedge clk);
    check("fill_idle_busy", 32'(busy), 32'd0);
    check("fill_idle_ready", 32'(ready), 32'd1);

    // Reset in the middle of data bit 3 with a second byte queued
    @(negedge clk);
    data       = 8'hA5;
    data_valid = 1'b1;
    @(negedge clk);
    data       = 8'h3C;
    @(negedge clk);
    data_valid = 1'b0;
    check("rst_mid_start", 32'(tx), 32'd0);
    repeat (4 * BC + BC / 2) @(negedge clk);
    check("rst_mid_bit3", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (3 * BC) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("rst_flushed", 32'(bad), 32'd0);
    fork
      send_byte(8'h11);
      begin
        logic [7:0]  b;
        logic [31:0] s;
        rx_byte(b, s);
        check("post_rst_byte", 32'(b), 32'h11);
      end
    join
    repeat (BC) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
